fp32_mul_scoreboard: RTL and testbench

Parametrised, synthesisable scoreboard for the pipelined fp32 multiplier. It delays issued operands, the golden expected result and the end-of-test marker by the DUT latency, then compares against the DUT output using a sign-correct ULP distance. It reports errors through counters, first-failure capture registers and a pass/done state machine rather than by stopping simulation, so the same block serves simulation benches and FPGA self-test. It sits beside the DUT and taps its inputs and output.

---
 rtl/fp32_mul_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_fp32_mul_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_scoreboard.sv
// Scoreboard for the pipelined fp32 multiplier: delays operands and golden result by the DUT
// latency, compares with a sign-correct ULP distance, and reports via counters, capture and FSM.
module fp32_mul_scoreboard #(
   parameter int unsigned LATENCY     = 5,
   parameter int unsigned TOL         = 1,
   parameter bit          NAN_EQ      = 1'b1,
   parameter bit          STOP_ON_ERR = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             val,
   input  logic             over,
   input  logic [31:0]      x1,
   input  logic [31:0]      x2,
   input  logic [31:0]      expct,
   input  logic [31:0]      y,
   output logic             chk_val,
   output logic             err,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [31:0]      fail_x1,
   output logic [31:0]      fail_x2,
   output logic [31:0]      fail_y,
   output logic [31:0]      fail_exp,
   output logic [1:0]       state,
   output logic             pass
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FAIL = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Delay line: index LATENCY-1 lines up with the DUT output y
   logic        val_sr_q  [LATENCY];
   logic        over_sr_q [LATENCY];
   logic [31:0] x1_sr_q   [LATENCY];
   logic [31:0] x2_sr_q   [LATENCY];
   logic [31:0] exp_sr_q  [LATENCY];

   state_e           state_q, state_d;
   logic             chk_val_q, err_q, pass_q, pass_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d;
   logic [31:0]      fail_x1_q, fail_x2_q, fail_y_q, fail_exp_q;

   logic               val_dl_c, over_dl_c, active_c, mis_c, fail_c, cap_c;
   logic [31:0]        exp_dl_c;
   logic signed [32:0] key_y_c, key_e_c;
   logic signed [33:0] diff_c;
   logic [33:0]        dist_c;
   logic               nan_y_c, nan_e_c;

   function automatic logic is_nan(input logic [31:0] b);
      return (&b[30:23]) && (|b[22:0]);
   endfunction

   // Sign-magnitude to two's complement so adjacent floats differ by one, through zero
   function automatic logic signed [32:0] fp_key(input logic [31:0] b);
      logic signed [32:0] mag;
      mag = $signed({2'b00, b[30:0]});
      return b[31] ? -mag : mag;
   endfunction

   always_comb begin
      val_dl_c  = val_sr_q[LATENCY-1];
      over_dl_c = over_sr_q[LATENCY-1];
      exp_dl_c  = exp_sr_q[LATENCY-1];
      key_y_c   = fp_key(y);
      key_e_c   = fp_key(exp_dl_c);
      diff_c    = {key_y_c[32], key_y_c} - {key_e_c[32], key_e_c};
      dist_c    = diff_c[33] ? 34'(-diff_c) : 34'(diff_c);
      nan_y_c   = is_nan(y);
      nan_e_c   = is_nan(exp_dl_c);
      mis_c     = 1'b0;
      if (nan_y_c && nan_e_c) begin
         mis_c = NAN_EQ ? 1'b0 : (y != exp_dl_c);
      end else if (nan_y_c || nan_e_c) begin
         mis_c = 1'b1;
      end else begin
         mis_c = dist_c > 34'(TOL);
      end
   end

   // Next-state, counters and pass decision
   always_comb begin
      active_c  = val_dl_c && ((state_q == S_IDLE) || (state_q == S_RUN));
      fail_c    = active_c && mis_c;
      cap_c     = fail_c && (err_cnt_q == '0);
      chk_cnt_d = chk_cnt_q;
      err_cnt_d = err_cnt_q;
      state_d   = state_q;
      if (active_c && (chk_cnt_q != CNT_MAX)) chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if (fail_c && (err_cnt_q != CNT_MAX))   err_cnt_d = err_cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE, S_RUN: begin
            if (over_dl_c)                      state_d = S_DONE;
            else if (fail_c && STOP_ON_ERR)     state_d = S_FAIL;
            else if (active_c)                  state_d = S_RUN;
         end
         S_FAIL:  if (over_dl_c) state_d = S_DONE;
         default: state_d = S_DONE;
      endcase
      pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            val_sr_q[i]  <= 1'b0;
            over_sr_q[i] <= 1'b0;
            x1_sr_q[i]   <= '0;
            x2_sr_q[i]   <= '0;
            exp_sr_q[i]  <= '0;
         end
         state_q    <= S_IDLE;
         chk_val_q  <= 1'b0;
         err_q      <= 1'b0;
         pass_q     <= 1'b0;
         chk_cnt_q  <= '0;
         err_cnt_q  <= '0;
         fail_x1_q  <= '0;
         fail_x2_q  <= '0;
         fail_y_q   <= '0;
         fail_exp_q <= '0;
      end else begin
         val_sr_q[0]  <= val;
         over_sr_q[0] <= over;
         x1_sr_q[0]   <= x1;
         x2_sr_q[0]   <= x2;
         exp_sr_q[0]  <= expct;
         for (int i = 1; i < int'(LATENCY); i++) begin
            val_sr_q[i]  <= val_sr_q[i-1];
            over_sr_q[i] <= over_sr_q[i-1];
            x1_sr_q[i]   <= x1_sr_q[i-1];
            x2_sr_q[i]   <= x2_sr_q[i-1];
            exp_sr_q[i]  <= exp_sr_q[i-1];
         end
         state_q   <= state_d;
         chk_val_q <= active_c;
         err_q     <= fail_c;
         pass_q    <= pass_d;
         chk_cnt_q <= chk_cnt_d;
         err_cnt_q <= err_cnt_d;
         if (cap_c) begin
            fail_x1_q  <= x1_sr_q[LATENCY-1];
            fail_x2_q  <= x2_sr_q[LATENCY-1];
            fail_y_q   <= y;
            fail_exp_q <= exp_dl_c;
         end
      end
   end

   assign chk_val  = chk_val_q;
   assign err      = err_q;
   assign chk_cnt  = chk_cnt_q;
   assign err_cnt  = err_cnt_q;
   assign fail_x1  = fail_x1_q;
   assign fail_x2  = fail_x2_q;
   assign fail_y   = fail_y_q;
   assign fail_exp = fail_exp_q;
   assign state    = state_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_fp32_mul_scoreboard.sv
// Bench: two scoreboard instances (default, and NAN_EQ=0/STOP_ON_ERR=0) behind a 5-stage fake DUT;
// expected results queued at issue, popped by a monitor whenever chk_val pulses.
module tb_fp32_mul_scoreboard;
   localparam int unsigned LAT = 5;

   logic        clk = 1'b0, rst = 1'b0, val = 1'b0, over = 1'b0;
   logic [31:0] x1 = '0, x2 = '0, expct = '0, ysrc = '0;
   logic [31:0] y;
   logic [31:0] ypipe [LAT];

   logic        a_chk_val, a_err, a_pass, b_chk_val, b_err, b_pass;
   logic [15:0] a_chk_cnt, a_err_cnt, b_chk_cnt, b_err_cnt;
   logic [31:0] a_fx1, a_fx2, a_fy, a_fe, b_fx1, b_fx2, b_fy, b_fe;
   logic [1:0]  a_state, b_state;

   typedef struct {int due; logic err;} exp_t;
   exp_t qa[$];
   exp_t qb[$];
   int n_tests = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Fake multiplier: LAT register stages from ysrc to y
   always @(posedge clk) begin
      ypipe[0] <= ysrc;
      for (int i = 1; i < int'(LAT); i++) ypipe[i] <= ypipe[i-1];
   end
   assign y = ypipe[LAT-1];

   fp32_mul_scoreboard #(.LATENCY(LAT), .TOL(1), .NAN_EQ(1'b1), .STOP_ON_ERR(1'b1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .val(val), .over(over), .x1(x1), .x2(x2), .expct(expct), .y(y),
      .chk_val(a_chk_val), .err(a_err), .chk_cnt(a_chk_cnt), .err_cnt(a_err_cnt),
      .fail_x1(a_fx1), .fail_x2(a_fx2), .fail_y(a_fy), .fail_exp(a_fe),
      .state(a_state), .pass(a_pass));

   fp32_mul_scoreboard #(.LATENCY(LAT), .TOL(1), .NAN_EQ(1'b0), .STOP_ON_ERR(1'b0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .val(val), .over(over), .x1(x1), .x2(x2), .expct(expct), .y(y),
      .chk_val(b_chk_val), .err(b_err), .chk_cnt(b_chk_cnt), .err_cnt(b_err_cnt),
      .fail_x1(b_fx1), .fail_x2(b_fx2), .fail_y(b_fy), .fail_exp(b_fe),
      .state(b_state), .pass(b_pass));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every chk_val pulse must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (a_chk_val) begin
            if (qa.size() == 0) check("a_unexpected_chk", 64'd1, 64'd0);
            else begin
               e = qa.pop_front();
               check("a_err", 64'(a_err), 64'(e.err));
               check("a_timing", 64'(cyc), 64'(e.due));
            end
         end
         if (b_chk_val) begin
            if (qb.size() == 0) check("b_unexpected_chk", 64'd1, 64'd0);
            else begin
               e = qb.pop_front();
               check("b_err", 64'(b_err), 64'(e.err));
               check("b_timing", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] yv, input bit ca, input bit ea, input bit cb,
                        input bit eb, input bit ov);
      exp_t t;
      val = 1'b1; over = ov; x1 = a; x2 = b; expct = e; ysrc = yv;
      t.due = cyc + 1 + int'(LAT);
      if (ca) begin t.err = ea; qa.push_back(t); end
      if (cb) begin t.err = eb; qb.push_back(t); end
      @(negedge clk);
      val = 1'b0; over = 1'b0;
   endtask

   task automatic send_over();
      over = 1'b1;
      @(negedge clk);
      over = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; val = 1'b0; over = 1'b0;
      repeat (2) @(negedge clk);
      qa.delete(); qb.delete();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic queues_drained(input string name);
      check({name, "_qa_empty"}, 64'(qa.size()), 64'd0);
      check({name, "_qb_empty"}, 64'(qb.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] e;
      @(negedge clk);
      check("reset_a_state", 64'(a_state), 64'd0);
      check("reset_a_chk_cnt", 64'(a_chk_cnt), 64'd0);
      check("reset_a_pass", 64'(a_pass), 64'd0);
      do_reset();
      check("idle_a_state", 64'(a_state), 64'd0);

      // 2.0 * 3.0 exact, end marker 10 cycles after issue
      issue(32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 1, 0, 1, 0, 0);
      idle(9);
      send_over();
      idle(LAT + 3);
      queues_drained("mul");
      check("mul_a_chk_cnt", 64'(a_chk_cnt), 64'd1);
      check("mul_a_err_cnt", 64'(a_err_cnt), 64'd0);
      check("mul_a_state", 64'(a_state), 64'd3);
      check("mul_a_pass", 64'(a_pass), 64'd1);
      check("mul_b_pass", 64'(b_pass), 64'd1);

      // ULP tolerance: 1 ulp accepted, 2 ulp rejected; STOP_ON_ERR freezes instance a
      do_reset();
      issue(32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800001, 1, 0, 1, 0, 0);
      issue(32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h3F800002, 1, 1, 1, 1, 0);
      issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 1, 0, 0);
      issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 1, 0, 0);
      idle(LAT + 3);
      queues_drained("ulp");
      check("ulp_a_state", 64'(a_state), 64'd2);
      check("ulp_a_chk_cnt", 64'(a_chk_cnt), 64'd2);
      check("ulp_a_err_cnt", 64'(a_err_cnt), 64'd1);
      check("ulp_a_fail_y", 64'(a_fy), 64'h3F800002);
      check("ulp_a_fail_exp", 64'(a_fe), 64'h3F800000);
      check("ulp_a_fail_x2", 64'(a_fx2), 64'h3F800002);
      check("ulp_b_state", 64'(b_state), 64'd1);
      check("ulp_b_chk_cnt", 64'(b_chk_cnt), 64'd4);
      send_over();
      idle(LAT + 3);
      check("ulp_a_done", 64'(a_state), 64'd3);
      check("ulp_a_pass", 64'(a_pass), 64'd0);
      check("ulp_b_pass", 64'(b_pass), 64'd0);

      // Signed zero, 1 ulp across zero, inf vs max finite, 2 ulp across zero
      do_reset();
      issue(32'h1, 32'h2, 32'h80000000, 32'h00000000, 1, 0, 1, 0, 0);
      issue(32'h1, 32'h2, 32'h80000000, 32'h00000001, 1, 0, 1, 0, 0);
      issue(32'h1, 32'h2, 32'h7F800000, 32'h7F7FFFFF, 1, 0, 1, 0, 0);
      issue(32'h1, 32'h2, 32'h80000001, 32'h00000001, 1, 1, 1, 1, 0);
      idle(LAT + 3);
      queues_drained("zero");
      check("zero_a_chk_cnt", 64'(a_chk_cnt), 64'd4);
      check("zero_a_err_cnt", 64'(a_err_cnt), 64'd1);
      check("zero_a_fail_exp", 64'(a_fe), 64'h80000001);

      // NaN handling
      do_reset();
      issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7F800001, 1, 0, 1, 1, 0);
      issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1, 0, 1, 0, 0);
      issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7F800000, 1, 1, 1, 1, 0);
      issue(32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000, 0, 0, 1, 0, 0);
      idle(LAT + 3);
      queues_drained("nan");
      check("nan_a_chk_cnt", 64'(a_chk_cnt), 64'd3);
      check("nan_a_err_cnt", 64'(a_err_cnt), 64'd1);
      check("nan_a_fail_y", 64'(a_fy), 64'h7F800000);
      check("nan_b_chk_cnt", 64'(b_chk_cnt), 64'd4);
      check("nan_b_err_cnt", 64'(b_err_cnt), 64'd2);
      check("nan_b_fail_y", 64'(b_fy), 64'h7F800001);

      // 20 back-to-back items, failures at 3 and 7, end marker rides on the last item
      do_reset();
      for (int i = 0; i < 20; i++) begin
         e = 32'h40000000 + (32'(i) << 4);
         issue(32'h3F800000 + 32'(i), 32'h40000000 + 32'(i), e,
               (i == 3 || i == 7) ? e + 32'd5 : e,
               i <= 3, i == 3, 1'b1, i == 3 || i == 7, i == 19);
      end
      idle(LAT + 3);
      queues_drained("b2b");
      check("b2b_b_chk_cnt", 64'(b_chk_cnt), 64'd20);
      check("b2b_b_err_cnt", 64'(b_err_cnt), 64'd2);
      check("b2b_b_fail_x1", 64'(b_fx1), 64'h3F800003);
      check("b2b_b_fail_x2", 64'(b_fx2), 64'h40000003);
      check("b2b_b_fail_y", 64'(b_fy), 64'h40000035);
      check("b2b_b_fail_exp", 64'(b_fe), 64'h40000030);
      check("b2b_b_state", 64'(b_state), 64'd3);
      check("b2b_b_pass", 64'(b_pass), 64'd0);
      check("b2b_a_chk_cnt", 64'(a_chk_cnt), 64'd4);
      check("b2b_a_state", 64'(a_state), 64'd3);

      // Failing compare and end marker in the same stage
      do_reset();
      issue(32'h1, 32'h2, 32'h3F800000, 32'h3F800010, 1, 1, 1, 1, 1);
      idle(LAT + 3);
      queues_drained("same");
      check("same_a_chk_cnt", 64'(a_chk_cnt), 64'd1);
      check("same_a_err_cnt", 64'(a_err_cnt), 64'd1);
      check("same_a_state", 64'(a_state), 64'd3);
      check("same_a_pass", 64'(a_pass), 64'd0);

      // Reset with three items in flight
      do_reset();
      issue(32'h5, 32'h6, 32'h3F800000, 32'h3F800003, 1, 1, 1, 1, 0);
      idle(LAT + 2);
      check("pre_rst_a_err_cnt", 64'(a_err_cnt), 64'd1);
      issue(32'h7, 32'h8, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0);
      issue(32'h7, 32'h8, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0);
      issue(32'h7, 32'h8, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      check("rst_a_chk_cnt", 64'(a_chk_cnt), 64'd0);
      check("rst_a_err_cnt", 64'(a_err_cnt), 64'd0);
      check("rst_a_state", 64'(a_state), 64'd0);
      check("rst_a_fail_y", 64'(a_fy), 64'd0);
      check("rst_b_chk_cnt", 64'(b_chk_cnt), 64'd0);
      qa.delete(); qb.delete();
      @(negedge clk);
      rst = 1'b1;
      idle(LAT + 3);
      check("post_rst_a_state", 64'(a_state), 64'd0);
      check("post_rst_b_chk_cnt", 64'(b_chk_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
